// File: rtl/multi_pulse_detector_if.sv
// Purpose : bundles the level inputs, per-channel mode selects and counter
//           clear with the pulse/level/count outputs of multi_pulse_detector.
// Latency : n/a (signal bundle only). Backpressure: none, outputs are strobes.
// Signals : L[CH], mode[2*CH], cnt_clr  - driven by the master (control side)
//           P[CH], level[CH], cnt[CH*CNT_W] - driven by the slave (detector)
interface multi_pulse_detector_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic [CH-1:0]       L;
  logic [2*CH-1:0]     mode;
  logic                cnt_clr;
  logic [CH-1:0]       P;
  logic [CH-1:0]       level;
  logic [CH*CNT_W-1:0] cnt;

  modport master (output L, mode, cnt_clr, input  P, level, cnt);
  modport slave  (input  L, mode, cnt_clr, output P, level, cnt);
endinterface

// File: rtl/multi_pulse_detector.sv
// Purpose : per-channel hold-time glitch filter + edge detector producing one
//           registered single-cycle pulse per accepted edge (rise/fall/both/off).
// Latency : P and level update on edge k+HOLD-1 when L first differs at edge k.
// Backpr. : none; pulses are fire-and-forget strobes.
// Ports   : clk            rising-edge clock
//           reset          asynchronous active-high reset, clears all state
//           bus (slave)    L, mode, cnt_clr in; P, level, cnt out
// Config  : define PULSE_COUNT_EN to compile in the saturating per-channel
//           event counters; otherwise cnt reads 0 and cnt_clr is ignored.
module multi_pulse_detector #(
  parameter int CH    = 4,
  parameter int HOLD  = 1,
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   reset,
  multi_pulse_detector_if.slave bus
);

  localparam int             RW     = $clog2(HOLD + 1);
  localparam logic [RW:0]    HOLD_V = HOLD[RW:0];

  logic [CH-1:0] r_f;
  logic [CH-1:0] r_p;
  logic [RW-1:0] r_run [CH];

  logic [CH-1:0] w_accept;
  logic [CH-1:0] w_pulse;
  logic [RW-1:0] w_run_nxt [CH];
  logic [RW:0]   w_run_inc [CH];

  always_comb begin
    w_accept = '0;
    w_pulse  = '0;
    for (int i = 0; i < CH; i++) begin
      w_run_nxt[i] = '0;
      // One bit wider than the run counter so the compare against HOLD
      // cannot wrap.
      w_run_inc[i] = {1'b0, r_run[i]} + (RW + 1)'(1);
      if (bus.L[i] != r_f[i]) begin
        if (w_run_inc[i] == HOLD_V) begin
          w_accept[i] = 1'b1;
        end else begin
          w_run_nxt[i] = w_run_inc[i][RW-1:0];
        end
      end
      // On accept the new filtered level equals L, so L gives the direction.
      if (w_accept[i]) begin
        unique case (bus.mode[2*i +: 2])
          2'b00:   w_pulse[i] = bus.L[i];
          2'b01:   w_pulse[i] = ~bus.L[i];
          2'b10:   w_pulse[i] = 1'b1;
          default: w_pulse[i] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f <= '0;
      r_p <= '0;
      for (int i = 0; i < CH; i++) begin
        r_run[i] <= '0;
      end
    end else begin
      // An accept only happens when L differs from f, so it is a toggle.
      r_f <= r_f ^ w_accept;
      r_p <= w_pulse;
      for (int i = 0; i < CH; i++) begin
        r_run[i] <= w_run_nxt[i];
      end
    end
  end

  assign bus.P     = r_p;
  assign bus.level = r_f;

`ifdef PULSE_COUNT_EN
  logic [CNT_W-1:0] r_cnt [CH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        // Clear wins over the old count but still records a coincident event.
        if (bus.cnt_clr) begin
          r_cnt[i] <= w_pulse[i] ? CNT_W'(1) : '0;
        end else if (w_pulse[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt_out
    assign bus.cnt[g*CNT_W +: CNT_W] = r_cnt[g];
  end
`else
  logic w_unused_cnt_clr;

  assign w_unused_cnt_clr = bus.cnt_clr;
  assign bus.cnt          = '0;
`endif

endmodule

// File: tb/tb_multi_pulse_detector.sv
`timescale 1ns/1ps
module tb_multi_pulse_detector;

  localparam int CH_A = 4, HOLD_A = 3, CW_A = 2;
  localparam int CH_B = 1, HOLD_B = 1, CW_B = 8;
`ifdef PULSE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_pulse_detector_if #(.CH(CH_A), .CNT_W(CW_A)) bus_a ();
  multi_pulse_detector_if #(.CH(CH_B), .CNT_W(CW_B)) bus_b ();

  multi_pulse_detector #(.CH(CH_A), .HOLD(HOLD_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  multi_pulse_detector #(.CH(CH_B), .HOLD(HOLD_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // Reference model: index 0 = dut_a, 1 = dut_b. An edge is accepted when the
  // last HOLD samples all differ from the filtered level (history is zeroed on
  // reset, which equals the reset level, so pre-reset samples never count).
  int         m_hold [2] = '{HOLD_A, HOLD_B};
  int         m_nch  [2] = '{CH_A, CH_B};
  int         m_cmax [2] = '{3, 255};
  logic       m_f    [2][4];
  logic       m_p    [2][4];
  logic [7:0] m_hist [2][4];
  int         m_cnt  [2][4];
  int         pc     [2][4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        m_f[d][c] = 1'b0; m_p[d][c] = 1'b0; m_hist[d][c] = 8'h00; m_cnt[d][c] = 0;
      end
  endtask

  task automatic clear_pc();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) pc[d][c] = 0;
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < m_nch[d]; c++) begin
        logic lv; logic [1:0] md; logic clr; logic [7:0] mask; logic acc; logic dir;
        if (d == 0) begin
          lv = bus_a.L[c]; md = bus_a.mode[2*c +: 2]; clr = bus_a.cnt_clr;
        end else begin
          lv = bus_b.L[0]; md = bus_b.mode; clr = bus_b.cnt_clr;
        end
        m_hist[d][c] = {m_hist[d][c][6:0], lv};
        mask = 8'((1 << m_hold[d]) - 1);
        acc  = ((m_hist[d][c] ^ {8{~m_f[d][c]}}) & mask) == 8'h00;
        dir  = (md == 2'b10) || (md == 2'b00 && lv) || (md == 2'b01 && !lv);
        if (acc) m_f[d][c] = lv;
        m_p[d][c] = acc && dir;
        if (CNT_EN) begin
          if (clr) m_cnt[d][c] = m_p[d][c] ? 1 : 0;
          else if (m_p[d][c] && m_cnt[d][c] < m_cmax[d]) m_cnt[d][c]++;
        end
      end
  endtask

  task automatic compare();
    logic [31:0] ep, el, ec;
    ep = '0; el = '0; ec = '0;
    for (int c = 0; c < CH_A; c++) begin
      ep[c] = m_p[0][c];
      el[c] = m_f[0][c];
      ec[c*CW_A +: CW_A] = CW_A'(m_cnt[0][c]);
      pc[0][c] += int'(bus_a.P[c]);
    end
    chk("P_a", 32'(bus_a.P), ep);
    chk("level_a", 32'(bus_a.level), el);
    chk("cnt_a", 32'(bus_a.cnt), ec);
    pc[1][0] += int'(bus_b.P[0]);
    chk("P_b", 32'(bus_b.P), 32'(m_p[1][0]));
    chk("level_b", 32'(bus_b.level), 32'(m_f[1][0]));
    chk("cnt_b", 32'(bus_b.cnt), 32'(8'(m_cnt[1][0])));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    compare();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Asserts reset between edges and checks outputs cleared without a clock.
  task automatic async_reset(input bit literal);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare();
    if (literal) begin
      chk("rst_P_a", 32'(bus_a.P), 32'h0);
      chk("rst_level_a", 32'(bus_a.level), 32'h0);
      chk("rst_cnt_a", 32'(bus_a.cnt), 32'h0);
    end
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pc_a();
    return {8'(pc[0][3]), 8'(pc[0][2]), 8'(pc[0][1]), 8'(pc[0][0])};
  endfunction

  initial begin
    reset         = 1'b1;
    bus_a.L       = '0;
    bus_a.mode    = 8'b11_10_01_00;  // ch0 rise, ch1 fall, ch2 both, ch3 off
    bus_a.cnt_clr = 1'b0;
    bus_b.L       = '0;
    bus_b.mode    = 2'b00;
    bus_b.cnt_clr = 1'b0;
    model_reset();
    clear_pc();
    #1;
    compare();
    chk("reset_P_a", 32'(bus_a.P), 32'h0);
    chk("reset_level_b", 32'(bus_b.level), 32'h0);
    ticks(2);
    reset = 1'b0;

    // HOLD=1: pulse the cycle after the first high sample, never retriggers.
    bus_b.L = 1'b1;
    tick();
    chk("b_hold1_pulse", 32'(bus_b.P), 32'h1);
    chk("b_hold1_level", 32'(bus_b.level), 32'h1);
    clear_pc();
    ticks(4);
    chk("b_no_retrigger", 32'(pc[1][0]), 32'h0);

    // HOLD=3: a 2-sample glitch is filtered out entirely.
    clear_pc();
    bus_a.L = 4'hF; ticks(2);
    bus_a.L = 4'h0; ticks(4);
    chk("a_glitch_pulses", pc_a(), 32'h0);
    chk("a_glitch_level", 32'(bus_a.level), 32'h0);

    // Sustained high: pulse after the third sample on rise/both channels.
    bus_a.L = 4'hF; ticks(2);
    chk("a_rise_early", 32'(bus_a.P), 32'h0);
    tick();
    chk("a_rise_P", 32'(bus_a.P), 32'h5);
    chk("a_rise_level", 32'(bus_a.level), 32'hF);
    clear_pc();
    ticks(3);
    chk("a_hold_no_retrig", pc_a(), 32'h0);

    bus_a.L = 4'h0; ticks(3);
    chk("a_fall_P", 32'(bus_a.P), 32'h6);
    chk("a_fall_level", 32'(bus_a.level), 32'h0);
    chk("a_cnt_after_2", 32'(bus_a.cnt), CNT_EN ? 32'h25 : 32'h0);

    // Back-to-back toggles at the minimum period; counters saturate at 3.
    clear_pc();
    for (int k = 0; k < 3; k++) begin
      bus_a.L = 4'hF; ticks(3);
      bus_a.L = 4'h0; ticks(3);
    end
    chk("a_toggle_pulses", pc_a(), 32'h00060303);
    chk("a_cnt_saturated", 32'(bus_a.cnt), CNT_EN ? 32'h3F : 32'h0);

    // Clear coincident with an event leaves that counter at 1.
    bus_a.L = 4'hF; ticks(2);
    bus_a.cnt_clr = 1'b1; tick();
    bus_a.cnt_clr = 1'b0;
    chk("a_clr_event_P", 32'(bus_a.P), 32'h5);
    chk("a_clr_event_cnt", 32'(bus_a.cnt), CNT_EN ? 32'h11 : 32'h0);
    bus_a.cnt_clr = 1'b1; tick();
    bus_a.cnt_clr = 1'b0;
    chk("a_clr_cnt", 32'(bus_a.cnt), 32'h0);

    // Reset mid-filter (run at 2 of 3), input then held high through release.
    bus_a.L = 4'h0; ticks(2);
    bus_a.L = 4'hF;
    async_reset(1'b1);
    ticks(2);
    chk("a_post_rst_early", 32'(bus_a.P), 32'h0);
    tick();
    chk("a_post_rst_rise", 32'(bus_a.P), 32'h5);
    // Reset while the pulse is high.
    async_reset(1'b1);
    ticks(3);
    chk("a_post_rst2_rise", 32'(bus_a.P), 32'h5);

    // Randomized traffic checked cycle by cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH_A; c++)
        if ($urandom_range(0, 4) == 0) bus_a.L[c] = ~bus_a.L[c];
      if ($urandom_range(0, 4) == 0) bus_b.L = ~bus_b.L;
      if ($urandom_range(0, 49) == 0) bus_a.mode = 8'($urandom);
      if ($urandom_range(0, 49) == 0) bus_b.mode = 2'($urandom);
      bus_a.cnt_clr = ($urandom_range(0, 39) == 0);
      bus_b.cnt_clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) async_reset(1'b0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_pulse_detector.md
# multi_pulse_detector

Parametrised, multi-channel successor to the single-channel level-to-pulse detector. Each of `CH` synchronous level inputs passes through a hold-time glitch filter. Each channel has its own edge-mode selection (rising, falling, both, or disabled). A detected edge produces exactly one registered one-cycle pulse. The block sits between synchronised button/status inputs and the control logic that consumes single-cycle event strobes.

## Interface
Parameters:
- `CH`, 4, number of independent channels (1..32).
- `HOLD`, 1, consecutive samples at a new level needed before it is accepted (1..255). `HOLD`=1 means no filtering.
- `CNT_W`, 8, width of each per-channel event counter (1..16).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `L`  in  CH  raw level inputs, already synchronous to `clk`.
- `mode`  in  2*CH  per-channel edge select, bits [2i+1:2i]:
  - 00 = rising
  - 01 = falling
  - 10 = both
  - 11 = disabled
- `cnt_clr`  in  1  synchronous clear of all event counters.
- `P`  out  CH  one-cycle event pulse per channel.
- `level`  out  CH  filtered (debounced) level per channel.
- `cnt`  out  CH*CNT_W  per-channel event counts; channel i occupies [i*CNT_W +: CNT_W].

## Operation
Per-channel state:
- `f[i]`: filtered level, reset 0.
- `r[i]`: run counter, width clog2(HOLD+1), reset 0.
- `P[i]`: registered pulse, reset 0.
- `cnt[i]`: event counter, reset 0.

At each rising `clk` edge, for every channel:
- If `L[i]` == `f[i]`: `r[i]` <= 0. No event.
- If `L[i]` != `f[i]` and `r[i]`+1 < `HOLD`: `r[i]` <= `r[i]`+1.
- If `L[i]` != `f[i]` and `r[i]`+1 == `HOLD`: `f[i]` <= `L[i]`, `r[i]` <= 0, and an accept event occurs. The edge direction is the new `f` value: 1 = rising, 0 = falling.
- `P[i]` <= accept AND the direction matches `mode[i]`. Otherwise `P[i]` <= 0.
- A glitch shorter than `HOLD` samples resets `r[i]`; it produces no pulse and no change of `level`.
- A sustained level never retriggers. `P[i]` is high for exactly one cycle per accepted edge.
- `mode`=11 forces `P[i]` to 0; the filter keeps tracking `L[i]`.
- `mode` is sampled on the accepting edge; a change applies to the next accept.
- `level` = `f`.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.
- After reset `f`=0. An input held high through reset deassertion therefore yields one rising event after `HOLD` samples.

## Timing
- Latency, `L` transition to `P`: with `L` first sampled at its new level on edge k, `P` is high during the cycle after edge k+`HOLD`-1.
  - `HOLD`=1: `P` is high the cycle after the first sampled high, matching the previous detector.
  - Pulse width is always one cycle.
- `level` changes on the same edge `P` rises.
- The minimum input period for back-to-back events is 2*`HOLD` cycles; `mode`=10 then pulses every `HOLD` cycles.
- `reset` asserted mid-filter or mid-pulse: `P`, `level`, `r` and `cnt` are 0 immediately, with no clock required.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `PULSE_COUNT_EN` defined: counters are compiled in.
  - `cnt[i]` increments on each edge that sets `P[i]`.
  - Saturates at 2^`CNT_W`-1.
  - `cnt_clr` clears all counters at the next edge. If `cnt_clr` and an event occur in the same cycle, that counter becomes 1.
- `PULSE_COUNT_EN` undefined: no counter logic is compiled; `cnt` is tied to 0 and `cnt_clr` is ignored. Ports are identical in both builds.

## Test plan
- `HOLD`=1, `CH`=1, `mode`=00: `L` rises and stays high 5 cycles -> `P`=1 for one cycle, the cycle after the first high sample; `level`=1.
- `HOLD`=3, `mode`=00:
  - 2-cycle high glitch -> no `P`, `level` stays 0.
  - 3-cycle high -> `P` one cycle after the third high sample.
- `HOLD`=2, `mode`=10: `L` toggles every 4 cycles for 16 cycles -> 4 pulses, alternating `level`. `mode`=01 on the same stimulus -> only the 2 falling pulses.
- `CH`=4 with mixed modes {00,01,10,11} and the same stimulus on all `L` bits -> pulses only on channels matching each mode; channel 3 never pulses.
- `reset` asserted asynchronously while `r`=2 of `HOLD`=3 and while `P`=1 -> all outputs 0 before the next edge. `L` held high after release -> one rising `P` after 3 samples.
- With `PULSE_COUNT_EN` and `CNT_W`=2:
  - 5 events -> `cnt`=3 (saturated).
  - `cnt_clr` coincident with an event -> `cnt`=1.
  - Without the macro -> `cnt`=0 throughout.
